// File: rtl/dino_pkg.sv
// Shared definitions for the dino runner: screen geometry, position width,
// game-state encoding and the modular scroll helper.
package dino_pkg;

  localparam int unsigned SCREEN_W = 320;
  localparam int unsigned SCREEN_H = 240;
  localparam int unsigned POS_W    = 9;
  localparam int unsigned SPEED_W  = 3;
  localparam int unsigned VEL_W    = 6;

  typedef logic [POS_W-1:0]          pos_t;
  typedef logic [SPEED_W-1:0]        speed_t;
  typedef logic signed [VEL_W-1:0]   vel_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_AIR  = 2'd2,
    ST_DEAD = 2'd3
  } state_e;

  // Move the background left by spd pixels, wrapping into 0..width-1.
  // Both branches stay inside the 9-bit range because spd is at most 7.
  function automatic pos_t scroll_wrap(input pos_t x, input speed_t spd, input pos_t width);
    pos_t res;
    if (x >= pos_t'(spd)) begin
      res = x - pos_t'(spd);
    end else begin
      res = x + width - pos_t'(spd);
    end
    return res;
  endfunction

endpackage

// File: rtl/dino_motion_ctrl_if.sv
// Control inputs and position outputs of the motion controller.
// master: game/frame logic that drives ticks and buttons and consumes positions.
// slave:  the motion controller itself.
interface dino_motion_ctrl_if;
  import dino_pkg::*;

  logic   frame_tick;
  logic   jump;
  logic   collide;
  pos_t   dino_x;
  pos_t   dino_y;
  pos_t   bg_x;
  state_e state;
  speed_t speed;

  modport master (
    output frame_tick, jump, collide,
    input  dino_x, dino_y, bg_x, state, speed
  );

  modport slave (
    input  frame_tick, jump, collide,
    output dino_x, dino_y, bg_x, state, speed
  );

endinterface

// File: rtl/bg_scroll_ctr.sv
// Background scroll offset with a frame-count driven speed ramp.
// restart has priority over step; step advances one frame of scrolling.
module bg_scroll_ctr
  import dino_pkg::*;
#(
  parameter int BASE_SPEED     = 2,
  parameter int MAX_SPEED      = 6,
  parameter int SPEEDUP_FRAMES = 600
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   step,
  input  logic   restart,
  output pos_t   bg_x,
  output speed_t speed
);

  localparam int CNT_W = (SPEEDUP_FRAMES > 1) ? $clog2(SPEEDUP_FRAMES) : 1;

  pos_t             bg_x_q, bg_x_d;
  speed_t           speed_q, speed_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  // Next scroll offset, speed and frame count for this cycle.
  always_comb begin
    bg_x_d      = bg_x_q;
    speed_d     = speed_q;
    frame_cnt_d = frame_cnt_q;
    if (restart) begin
      bg_x_d      = '0;
      speed_d     = speed_t'(BASE_SPEED);
      frame_cnt_d = '0;
    end else if (step) begin
      // The scroll uses the speed in force before any ramp on this frame.
      bg_x_d = scroll_wrap(bg_x_q, speed_q, pos_t'(SCREEN_W));
      if (frame_cnt_q == CNT_W'(SPEEDUP_FRAMES - 1)) begin
        frame_cnt_d = '0;
        if (speed_q < speed_t'(MAX_SPEED)) begin
          speed_d = speed_q + speed_t'(1);
        end
      end else begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end
    end
  end

  // Scroll state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bg_x_q      <= '0;
      speed_q     <= speed_t'(BASE_SPEED);
      frame_cnt_q <= '0;
    end else begin
      bg_x_q      <= bg_x_d;
      speed_q     <= speed_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bg_x  = bg_x_q;
  assign speed = speed_q;

endmodule

// File: rtl/dino_motion_ctrl.sv
// Per-frame dino motion controller: game-state machine, jump request latch
// and vertical jump physics. Background scrolling lives in bg_scroll_ctr.
module dino_motion_ctrl
  import dino_pkg::*;
#(
  parameter int GROUND_Y       = 180,
  parameter int DINO_X         = 40,
  parameter int JUMP_V         = 9,
  parameter int GRAVITY        = 1,
  parameter int BASE_SPEED     = 2,
  parameter int MAX_SPEED      = 6,
  parameter int SPEEDUP_FRAMES = 600
) (
  input  logic                clk,
  input  logic                rst,
  dino_motion_ctrl_if.slave   bus
);

  localparam vel_t              VEL_JUMP   = vel_t'(-JUMP_V);
  localparam vel_t              VEL_GRAV   = vel_t'(GRAVITY);
  localparam logic signed [9:0] Y_GROUND_S = 10'(GROUND_Y);

  state_e state_q, state_d;
  vel_t   vel_q, vel_d;
  pos_t   dino_y_q, dino_y_d;
  logic   jump_q, jump_d;
  logic   jump_pend_q, jump_pend_d;

  logic              jump_rise;
  logic              scroll_step;
  logic              scroll_restart;
  logic signed [9:0] y_next;
  pos_t              bg_x_w;
  speed_t            speed_w;

  assign jump_rise = bus.jump & ~jump_q;

  // Jump request latch: an edge always sets it, even on a tick cycle, so an
  // edge coinciding with a tick is serviced on the following frame.
  always_comb begin
    jump_d      = bus.jump;
    jump_pend_d = jump_pend_q;
    if (jump_rise) begin
      jump_pend_d = 1'b1;
    end else if (bus.frame_tick) begin
      jump_pend_d = 1'b0;
    end
  end

  // Game-state next-state and physics; a collision pre-empts the frame update.
  always_comb begin
    state_d        = state_q;
    vel_d          = vel_q;
    dino_y_d       = dino_y_q;
    scroll_step    = 1'b0;
    scroll_restart = 1'b0;
    y_next         = $signed({1'b0, dino_y_q}) + $signed({{4{vel_q[VEL_W-1]}}, vel_q});

    if (bus.collide && (state_q == ST_RUN || state_q == ST_AIR)) begin
      state_d = ST_DEAD;
    end else if (bus.frame_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (jump_pend_q) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          scroll_step = 1'b1;
          if (jump_pend_q) begin
            state_d = ST_AIR;
            vel_d   = VEL_JUMP;
          end
        end
        ST_AIR: begin
          scroll_step = 1'b1;
          vel_d       = vel_q + VEL_GRAV;
          // Only a descending dino can land; the ascent starts at ground level.
          if (vel_q > 6'sd0 && y_next >= Y_GROUND_S) begin
            dino_y_d = pos_t'(GROUND_Y);
            vel_d    = '0;
            state_d  = ST_RUN;
          end else if (y_next < 10'sd0) begin
            dino_y_d = '0;
          end else begin
            dino_y_d = y_next[POS_W-1:0];
          end
        end
        ST_DEAD: begin
          if (jump_pend_q) begin
            state_d        = ST_RUN;
            dino_y_d       = pos_t'(GROUND_Y);
            vel_d          = '0;
            scroll_restart = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, physics and jump-latch registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      vel_q       <= '0;
      dino_y_q    <= pos_t'(GROUND_Y);
      jump_q      <= 1'b0;
      jump_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vel_q       <= vel_d;
      dino_y_q    <= dino_y_d;
      jump_q      <= jump_d;
      jump_pend_q <= jump_pend_d;
    end
  end

  bg_scroll_ctr #(
    .BASE_SPEED     (BASE_SPEED),
    .MAX_SPEED      (MAX_SPEED),
    .SPEEDUP_FRAMES (SPEEDUP_FRAMES)
  ) u_scroll (
    .clk     (clk),
    .rst     (rst),
    .step    (scroll_step),
    .restart (scroll_restart),
    .bg_x    (bg_x_w),
    .speed   (speed_w)
  );

  assign bus.dino_x = pos_t'(DINO_X);
  assign bus.dino_y = dino_y_q;
  assign bus.bg_x   = bg_x_w;
  assign bus.state  = state_q;
  assign bus.speed  = speed_w;

endmodule
